// File: rtl/portal_msg_deframer.sv
// portal_msg_deframer: splits a 32-bit beat stream into portal messages.
// One header word (method id in [31:16], total length L in [15:0]) is
// followed by L-1 payload words. One complete message is buffered and
// held for the request demux; oversize or zero-length messages are
// dropped and flagged with err_oversize.
// Optional build macro PORTAL_DEFRAMER_STATS_EN adds message, drop and
// beat counters as extra outputs.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_HDR   | waiting for a header beat
// S_PAYLOAD | storing payload beats into the buffer
// S_DROP  | discarding the payload of an oversize message
// S_HOLD  | complete message presented, upstream stalled until deq
module portal_msg_deframer #(
  parameter int MAX_WORDS = 16,
  localparam int AW = $clog2(MAX_WORDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          beat_rdy,
  input  logic [31:0]   beat,
  output logic          beat_en,
  output logic          msg_valid,
  output logic [15:0]   msg_method,
  output logic [15:0]   msg_words,
  input  logic [AW-1:0] msg_rd_addr,
  output logic [31:0]   msg_rd_data,
  input  logic          msg_deq,
  output logic          err_oversize
`ifdef PORTAL_DEFRAMER_STATS_EN
  ,
  output logic [31:0]   stat_msgs,
  output logic [31:0]   stat_drops,
  output logic [31:0]   stat_beats
`endif
);

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP, S_HOLD} state_t;

  // Compare at 17 bits so L=0xFFFF cannot wrap past the limit.
  localparam logic [16:0] LEN_LIMIT = 17'(MAX_WORDS + 1);

  state_t        state, state_nxt;
  logic [31:0]   mem [MAX_WORDS];
  logic [AW-1:0] wptr;
  logic [15:0]   drop_cnt;
  logic [15:0]   hdr_len;
  logic          xfer;
  logic          len_zero, len_one, len_big;
  logic          hdr_xfer, err_set, last_payload;

  assign beat_en      = beat_rdy && (state != S_HOLD);
  assign xfer         = beat_en;
  assign msg_valid    = (state == S_HOLD);
  assign hdr_len      = beat[15:0];
  assign len_zero     = (hdr_len == 16'd0);
  assign len_one      = (hdr_len == 16'd1);
  assign len_big      = ({1'b0, hdr_len} > LEN_LIMIT);
  assign hdr_xfer     = (state == S_HDR) && xfer;
  assign err_set      = hdr_xfer && (len_zero || len_big);
  assign last_payload = ({{(16-AW){1'b0}}, wptr} == (msg_words - 16'd1));

  // Next-state decode; transitions happen only on a beat transfer or deq.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (xfer) begin
          if (len_zero)     state_nxt = S_HDR;
          else if (len_one) state_nxt = S_HOLD;
          else if (len_big) state_nxt = S_DROP;
          else              state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (xfer && last_payload)        state_nxt = S_HOLD;
      S_DROP:    if (xfer && drop_cnt == 16'd1)   state_nxt = S_HDR;
      S_HOLD:    if (msg_deq)                     state_nxt = S_HDR;
      default:   state_nxt = S_HDR;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= S_HDR;
    else      state <= state_nxt;
  end

  // Header latch, write pointer, drop counter and error pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      msg_method   <= '0;
      msg_words    <= '0;
      wptr         <= '0;
      drop_cnt     <= '0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= err_set;
      if (hdr_xfer && !len_zero && !len_big) begin
        msg_method <= beat[31:16];
        msg_words  <= hdr_len - 16'd1;
        wptr       <= '0;
      end
      if (hdr_xfer && len_big)
        drop_cnt <= hdr_len - 16'd1;
      if (state == S_PAYLOAD && xfer)
        wptr <= wptr + AW'(1);
      if (state == S_DROP && xfer)
        drop_cnt <= drop_cnt - 16'd1;
    end
  end

  // Payload buffer write; contents are not reset.
  always_ff @(posedge CLK) begin
    if (RST && state == S_PAYLOAD && xfer)
      mem[wptr] <= beat;
  end

  // Registered random-access read port.
  always_ff @(posedge CLK) begin
    if (!RST) msg_rd_data <= '0;
    else      msg_rd_data <= mem[msg_rd_addr];
  end

`ifdef PORTAL_DEFRAMER_STATS_EN
  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stat_msgs  <= '0;
      stat_drops <= '0;
      stat_beats <= '0;
    end else begin
      if (state_nxt == S_HOLD && state != S_HOLD) stat_msgs <= stat_msgs + 32'd1;
      if (err_set) stat_drops <= stat_drops + 32'd1;
      if (xfer)    stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_portal_msg_deframer.sv
// Self-checking bench for portal_msg_deframer: a driver issues messages
// and pushes expected events into a scoreboard; a monitor consumes them.
module tb_portal_msg_deframer;
  localparam int MAX_WORDS = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          beat_rdy = 1'b0;
  logic [31:0]   beat = '0;
  logic          msg_deq = 1'b0;
  logic [AW-1:0] msg_rd_addr = '0;
  logic          beat_en, msg_valid, err_oversize;
  logic [15:0]   msg_method, msg_words;
  logic [31:0]   msg_rd_data;
`ifdef PORTAL_DEFRAMER_STATS_EN
  logic [31:0]   stat_msgs, stat_drops, stat_beats;
`endif

  portal_msg_deframer #(.MAX_WORDS(MAX_WORDS)) dut (
    .CLK(CLK), .RST(RST), .beat_rdy(beat_rdy), .beat(beat), .beat_en(beat_en),
    .msg_valid(msg_valid), .msg_method(msg_method), .msg_words(msg_words),
    .msg_rd_addr(msg_rd_addr), .msg_rd_data(msg_rd_data), .msg_deq(msg_deq),
    .err_oversize(err_oversize)
`ifdef PORTAL_DEFRAMER_STATS_EN
    , .stat_msgs(stat_msgs), .stat_drops(stat_drops), .stat_beats(stat_beats)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int rdy_pct = 100;
  int model_msgs = 0, model_drops = 0, model_beats = 0;
  bit mon_en = 0;
  bit holding = 0;

  // Scoreboard: one entry per expected event (drop pulse or held message).
  bit          exp_drop[$];
  int          exp_cyc[$];
  logic [15:0] exp_method[$];
  int          exp_words[$];
  logic [31:0] exp_data[$];
  logic [31:0] pay[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one beat until it transfers; xc is the cycle index at which the
  // resulting registered effect becomes visible.
  task automatic xfer(input logic [31:0] w, output int xc);
    int tries;
    bit done;
    tries = 0;
    done = 0;
    xc = -1;
    while (!done) begin
      @(negedge CLK);
      beat_rdy = ($urandom_range(0, 99) < rdy_pct);
      beat = beat_rdy ? w : $urandom();
      #1;
      if (beat_rdy && beat_en) begin
        xc = cyc + 1;
        model_beats++;
        done = 1;
      end else if (++tries > 5000) begin
        n_tests++;
        n_fail++;
        $display("FAIL xfer_timeout: beat %h never accepted", w);
        done = 1;
      end
    end
  endtask

  // Send a full message of total length len and record what must follow.
  task automatic send_msg(input logic [15:0] method, input int len);
    int c;
    logic [31:0] w;
    xfer({method, len[15:0]}, c);
    if (len == 0 || len > MAX_WORDS + 1) begin
      exp_drop.push_back(1); exp_cyc.push_back(c);
      exp_method.push_back(16'd0); exp_words.push_back(0);
      model_drops++;
      for (int i = 1; i < len; i++) begin
        w = $urandom();
        xfer(w, c);
      end
    end else begin
      for (int i = 1; i < len; i++) begin
        w = (pay.size() > 0) ? pay.pop_front() : $urandom();
        exp_data.push_back(w);
        xfer(w, c);
      end
      exp_drop.push_back(0); exp_cyc.push_back(c);
      exp_method.push_back(method); exp_words.push_back(len - 1);
      model_msgs++;
    end
  endtask

  // Monitor: checks handshake rule, drop pulses, held messages and reads.
  initial begin
    int rd_i, pend, wait_n, words, n_held, c;
    bit deq_phase, dr;
    logic [15:0] meth;
    logic [31:0] d[$];
    rd_i = 0; pend = -1; wait_n = 0; words = 0; n_held = 0; deq_phase = 0;
    meth = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (mon_en && RST === 1'b1) begin
        check("beat_en_rule", 32'(beat_en), 32'(beat_rdy && !msg_valid));
        if (!holding && exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
          check("event_cycle", cyc, exp_cyc[0]);
          dr = exp_drop.pop_front(); c = exp_cyc.pop_front();
          void'(exp_method.pop_front());
          words = exp_words.pop_front();
          if (!dr) for (int i = 0; i < words; i++) void'(exp_data.pop_front());
        end
        if (err_oversize === 1'b1) begin
          if (exp_drop.size() == 0 || exp_drop[0] == 0)
            check("err_oversize_unexpected", 32'(err_oversize), 32'd0);
          else begin
            dr = exp_drop.pop_front(); c = exp_cyc.pop_front();
            void'(exp_method.pop_front()); void'(exp_words.pop_front());
            check("drop_cycle", cyc, c);
          end
        end
        if (deq_phase) begin
          check("valid_after_deq", 32'(msg_valid), 32'd0);
          msg_deq = 1'b0;
          deq_phase = 0;
          holding = 0;
        end else if (holding) begin
          msg_deq = 1'b0;
          check("valid_hold", 32'(msg_valid), 32'd1);
          check("method_stable", 32'(msg_method), 32'(meth));
          check("words_stable", 32'(msg_words), words);
          if (pend >= 0) begin
            check($sformatf("rd_data[%0d]", pend), msg_rd_data, d[pend]);
            pend = -1;
          end
          if (rd_i < words) begin
            msg_rd_addr = AW'(rd_i);
            pend = rd_i;
            rd_i++;
          end else if (wait_n > 0) begin
            wait_n--;
          end else begin
            msg_deq = 1'b1;
            deq_phase = 1;
          end
        end else if (msg_valid === 1'b1) begin
          msg_deq = 1'b0;
          if (exp_drop.size() == 0 || exp_drop[0] == 1) begin
            check("msg_valid_unexpected", 32'(msg_valid), 32'd0);
            msg_deq = 1'b1;
          end else begin
            dr = exp_drop.pop_front(); c = exp_cyc.pop_front();
            meth = exp_method.pop_front(); words = exp_words.pop_front();
            check("valid_cycle", cyc, c);
            check("msg_method", 32'(msg_method), 32'(meth));
            check("msg_words", 32'(msg_words), words);
            d.delete();
            for (int i = 0; i < words; i++) d.push_back(exp_data.pop_front());
            holding = 1; rd_i = 0; pend = -1;
            wait_n = (n_held == 0 || $urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 3));
            n_held++;
          end
        end else begin
          // Deq with nothing held must be ignored.
          msg_deq = ($urandom_range(0, 7) == 0);
        end
      end
    end
  end

  initial begin
    int c, t;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    check("rst_msg_valid", 32'(msg_valid), 32'd0);
    check("rst_msg_method", 32'(msg_method), 32'd0);
    check("rst_msg_words", 32'(msg_words), 32'd0);
    check("rst_rd_data", msg_rd_data, 32'd0);
    check("rst_err", 32'(err_oversize), 32'd0);
    RST = 1'b1;
    mon_en = 1;

    // Reset in the middle of a message: partial message must vanish.
    rdy_pct = 100;
    xfer(32'h0009_0004, c);
    xfer(32'h0000_0AAA, c);
    @(negedge CLK); beat_rdy = 1'b0; RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    #1;
    check("midrst_msg_valid", 32'(msg_valid), 32'd0);
    check("midrst_msg_words", 32'(msg_words), 32'd0);
    check("midrst_msg_method", 32'(msg_method), 32'd0);
    check("midrst_beat_en", 32'(beat_en), 32'd0);
    model_msgs = 0; model_drops = 0; model_beats = 0;

    // Directed scenarios with back-to-back beats.
    pay = '{32'h11, 32'h22, 32'h33};
    send_msg(16'd5, 4);
    send_msg(16'd7, 1);
    send_msg(16'd2, 19);
    pay = '{32'hAB};
    send_msg(16'd3, 2);
    send_msg(16'd4, 0);
    send_msg(16'd6, 17);
    send_msg(16'd8, 18);
    rdy_pct = 50;
    send_msg(16'd9, 3);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int r, len;
      rdy_pct = $urandom_range(30, 100);
      r = $urandom_range(0, 99);
      if (r < 8)       len = 0;
      else if (r < 18) len = $urandom_range(18, 24);
      else if (r < 28) len = 1;
      else             len = $urandom_range(2, MAX_WORDS + 1);
      send_msg(16'($urandom()), len);
    end
    @(negedge CLK);
    beat_rdy = 1'b0;

    t = 0;
    while ((exp_drop.size() > 0 || holding) && t < 500) begin
      @(negedge CLK);
      t++;
    end
    if (exp_drop.size() > 0 || holding) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending", exp_drop.size());
    end
    repeat (3) @(negedge CLK);
    #2;
`ifdef PORTAL_DEFRAMER_STATS_EN
    check("stat_msgs", stat_msgs, model_msgs);
    check("stat_drops", stat_drops, model_drops);
    check("stat_beats", stat_beats, model_beats);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/portal_msg_deframer.md
Name: portal_msg_deframer

Overview:
- Sits directly downstream of the simulation message-sink stage.
- Pulls 32-bit beats through its RDY/EN handshake and splits the stream into portal messages: one header word, then N-1 payload words.
- Buffers one complete message and presents its method id, payload count and random-access payload to the portal request demux.
- Drops oversize or malformed messages and flags them.

Parameters:
- MAX_WORDS, 16: payload capacity in 32-bit words; the header is not stored.
- AW, $clog2(MAX_WORDS): payload read-address width. Derived, never overridden.

Ports:
- CLK  in  1  sole clock; all logic on posedge.
- RST  in  1  reset. One clock; reset is synchronous and active-low.
- beat_rdy  in  1  upstream has a valid beat.
- beat  in  32  upstream beat data.
- beat_en  out  1  consume beat this cycle.
- msg_valid  out  1  complete message held.
- msg_method  out  16  method id of held message.
- msg_words  out  16  payload word count of held message, 0..MAX_WORDS.
- msg_rd_addr  in  AW  payload word index.
- msg_rd_data  out  32  payload word, registered.
- msg_deq  in  1  release held message.
- err_oversize  out  1  one-cycle pulse when a message is dropped.

Behaviour:
- Header word: beat[31:16] = method id; beat[15:0] = L, total words including header.
- Reset (RST==0 at posedge) forces:
  - state HDR, msg_valid=0, msg_method=0, msg_words=0, msg_rd_data=0, err_oversize=0.
  - Write pointer and drop counter cleared; buffer contents undefined.
- Reset mid-message discards the partial message; the upstream beats it consumed are lost.
- beat_en = beat_rdy && state in {HDR, PAYLOAD, DROP}. It is combinational and never asserted in HOLD.
- A beat transfers only on a cycle with beat_en==1.
- States and transitions, all on a transfer unless noted:
  - HDR, L==1: latch method, msg_words=0, go to HOLD next cycle.
  - HDR, 2 <= L <= MAX_WORDS+1: latch method and L-1, clear write pointer, go to PAYLOAD.
  - HDR, L==0: pulse err_oversize, stay in HDR. Header only is consumed.
  - HDR, L > MAX_WORDS+1: pulse err_oversize in the cycle after the header transfer, load drop count L-1, go to DROP.
  - PAYLOAD: write beat to buf[wptr], wptr++. On the transfer where wptr==msg_words-1, go to HOLD.
  - DROP: discard beat, decrement count. At count reaching 0, go to HDR. Nothing is presented.
  - HOLD: msg_valid=1. msg_deq==1 returns to HDR next cycle. No same-cycle bypass, so beat_en is first allowed one cycle after the deq.
- msg_deq while msg_valid==0 is ignored.
- msg_rd_data <= buf[msg_rd_addr] every cycle: one-cycle latency.
- msg_rd_addr >= msg_words returns stale or undefined data, with no error.
- msg_method and msg_words are stable throughout HOLD.
- Upstream stalls (beat_rdy==0) in any state: the state holds and no pointer moves.
- Widths: L is treated as unsigned 16-bit; the comparison against MAX_WORDS+1 is done at 17 bits, so L=0xFFFF never wraps.

Optional Feature:
- Macro: PORTAL_DEFRAMER_STATS_EN.
- When defined, three extra outputs are added:
  - stat_msgs [31:0]: increments on each entry to HOLD.
  - stat_drops [31:0]: increments on each err_oversize pulse.
  - stat_beats [31:0]: increments on each beat transfer.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Header 0x0005_0004, then payload 0x11, 0x22, 0x33, back-to-back with beat_rdy=1:
  - msg_valid=1 on the 5th cycle after the header transfer cycle is counted as cycle 1, i.e. the cycle after the last payload transfer.
  - msg_method=5, msg_words=3.
  - Reading addresses 0, 1, 2 returns 0x11, 0x22, 0x33, each one cycle later.
- Header 0x0007_0001: msg_valid=1 next cycle, msg_words=0. msg_deq, then beat_en=0 for exactly that cycle and returns to 1 after.
- MAX_WORDS=16, header 0x0002_0013 (L=19), then 18 beats, then valid header 0x0003_0002 + 0xAB:
  - err_oversize pulses once; no msg_valid for the first message.
  - Second message presents method 3, msg_words=1, data 0xAB.
- Header 0x0009_0003 then payload with beat_rdy toggling 1,0,0,1: payload is captured correctly and beat_en is never high while beat_rdy=0.
- While a message is in HOLD with beat_rdy=1, assert nothing for 10 cycles:
  - beat_en stays 0 and msg_valid stays 1.
  - After msg_deq, the next header is accepted.
- Drive RST=0 for one cycle after 1 of 3 payload words: msg_valid=0, state HDR, and the next header parses cleanly.
- With PORTAL_DEFRAMER_STATS_EN, after the first and third scenarios: stat_msgs=2, stat_drops=1, stat_beats=25.
